// File: rtl/stack_ctrl_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stack_seq_pkg
// Shared types and constants for the stack control sequencer:
//   cmd_op_e   - command opcodes accepted from the control unit
//   state_e    - sequencer FSM states
//   SRC_*      - SEL_MUX_STACK source selects
//   ERR_*      - ERR_CODE values
//   strobes_t  - bundle of all registered control outputs
//   decode_state() - Moore strobe pattern for each state
// ---------------------------------------------------------------------------
package stack_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_PUSH_ALU  = 4'd1,
        OP_PUSH_RET  = 4'd2,
        OP_PUSH_ARG  = 4'd3,
        OP_DUP       = 4'd4,
        OP_POP       = 4'd5,
        OP_LOAD_MEM  = 4'd6,
        OP_STORE_MEM = 4'd7,
        OP_SET_TOS   = 4'd8
    } cmd_op_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_STK,
        S_RD_MEM,
        S_PUSH_LATCH,
        S_PUSH_WR,
        S_POP,
        S_WM_LATCH,
        S_WM_WR,
        S_SET_TOS,
        S_ERR
    } state_e;

    localparam logic [2:0] SRC_ALU = 3'b000;
    localparam logic [2:0] SRC_MEM = 3'b001;
    localparam logic [2:0] SRC_RET = 3'b010;
    localparam logic [2:0] SRC_ARG = 3'b011;
    localparam logic [2:0] SRC_STK = 3'b100;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    typedef struct packed {
        logic [2:0] sel_mux_stack;
        logic       reg_read_stack;
        logic       reg_write_stack;
        logic       reg_read_mem;
        logic       reg_write_mem;
        logic       sel_mux_tos;
        logic       ctrl_reg_tos;
        logic       sel_tos_updater;
        logic       ctrl_stack;
        logic       ctrl_mem_ext;
        logic       cmd_done;
        logic       cmd_err;
    } strobes_t;

    // Strobe pattern presented while the FSM sits in state st. src is only
    // meaningful in PUSH_LATCH; elsewhere the stack mux rests on the ALU.
    function automatic strobes_t decode_state(input state_e st, input logic [2:0] src);
        strobes_t s;
        s = '0;
        case (st)
            S_RD_STK:     s.reg_read_stack = 1'b1;
            S_RD_MEM:     s.reg_read_mem   = 1'b1;
            S_PUSH_LATCH: begin
                s.sel_mux_stack   = src;
                s.reg_write_stack = 1'b1;
                s.ctrl_reg_tos    = 1'b1;
                s.sel_tos_updater = 1'b1;
            end
            S_PUSH_WR: begin
                s.ctrl_stack = 1'b1;
                s.cmd_done   = 1'b1;
            end
            S_POP: begin
                s.ctrl_reg_tos = 1'b1;
                s.cmd_done     = 1'b1;
            end
            S_WM_LATCH:   s.reg_write_mem = 1'b1;
            S_WM_WR: begin
                s.ctrl_mem_ext = 1'b1;
                s.ctrl_reg_tos = 1'b1;
                s.cmd_done     = 1'b1;
            end
            S_SET_TOS: begin
                s.sel_mux_tos  = 1'b1;
                s.ctrl_reg_tos = 1'b1;
                s.cmd_done     = 1'b1;
            end
            S_ERR:        s.cmd_err = 1'b1;
            default:      s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stack_ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// stack_ctrl_sequencer_if
// Command channel between the main control unit (master) and the stack
// sequencer (slave).
//   CMD_OP/CMD_VALID/CMD_TOS_DEPTH : command from master
//   CMD_READY                      : sequencer idle, can accept
//   CMD_DONE/CMD_ERR               : one-cycle completion / rejection pulses
//   ERR_CODE                       : outcome of the last accepted command
// ---------------------------------------------------------------------------
interface stack_ctrl_sequencer_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic [3:0]          CMD_OP;
    logic                CMD_VALID;
    logic                CMD_READY;
    logic [ADDR_WIDTH:0] CMD_TOS_DEPTH;
    logic                CMD_DONE;
    logic                CMD_ERR;
    logic [1:0]          ERR_CODE;

    modport master (
        output CMD_OP, CMD_VALID, CMD_TOS_DEPTH,
        input  CMD_READY, CMD_DONE, CMD_ERR, ERR_CODE
    );

    modport slave (
        input  CMD_OP, CMD_VALID, CMD_TOS_DEPTH,
        output CMD_READY, CMD_DONE, CMD_ERR, ERR_CODE
    );
endinterface

// File: rtl/stack_ctrl_sequencer_depth.sv
// ---------------------------------------------------------------------------
// stack_depth_counter
// Tracks the number of stacked entries (0 .. 2**ADDR_WIDTH).
//   clk, reset (sync, active-low)
//   inc_i / dec_i / load_i : one step up / down / load load_val_i (load wins)
//   depth_o                : current depth
//   full_o / empty_o       : depth at maximum / zero
// Callers guarantee inc never happens when full and dec never when empty.
// ---------------------------------------------------------------------------
module stack_depth_counter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                load_i,
    input  logic [ADDR_WIDTH:0] load_val_i,
    output logic [ADDR_WIDTH:0] depth_o,
    output logic                full_o,
    output logic                empty_o
);
    localparam logic [ADDR_WIDTH:0] MAX_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] depth_q, depth_d;

    always_comb begin
        depth_d = depth_q;
        if (load_i)
            depth_d = load_val_i;
        else if (inc_i)
            depth_d = depth_q + ONE;
        else if (dec_i)
            depth_d = depth_q - ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    assign depth_o = depth_q;
    assign full_o  = (depth_q == MAX_DEPTH);
    assign empty_o = (depth_q == '0);
endmodule

// File: rtl/stack_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// stack_ctrl_sequencer
// Accepts one stack command at a time over cmd (slave modport) and expands it
// into the multi-cycle strobe sequence for the stack/TOS datapath, rejecting
// commands that would overflow/underflow the stack or use an illegal opcode.
//   clk, reset (sync, active-low)
//   cmd                 : command channel (op, valid/ready, done/err, code)
//   STACK_DEPTH         : current number of stacked entries
//   SEL_MUX_STACK, CTRL_REG_*, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER,
//   CTRL_STACK, CTRL_MEM_EXT : registered datapath control strobes
// ---------------------------------------------------------------------------
module stack_ctrl_sequencer
    import stack_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    stack_ctrl_sequencer_if.slave cmd,
    output logic [ADDR_WIDTH:0]  STACK_DEPTH,
    output logic [2:0]           SEL_MUX_STACK,
    output logic                 CTRL_REG_READ_STACK,
    output logic                 CTRL_REG_WRITE_STACK,
    output logic                 CTRL_REG_READ_MEM,
    output logic                 CTRL_REG_WRITE_MEM,
    output logic                 SEL_MUX_TOS,
    output logic                 CTRL_REG_TOS,
    output logic                 SEL_TOS_UPDATER,
    output logic                 CTRL_STACK,
    output logic                 CTRL_MEM_EXT
);
    localparam logic [ADDR_WIDTH:0] MAX_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e              state_q, state_d;
    cmd_op_e             op_q, op_d;
    logic [2:0]          src_q, src_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ADDR_WIDTH:0] tos_val_q, tos_val_d;
    logic                ready_q, ready_d;
    strobes_t            strb_q, strb_d;
    logic                nop_done;
    logic                full, empty;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        err_code_d = err_code_q;
        tos_val_d  = tos_val_q;
        nop_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd.CMD_VALID && ready_q) begin
                    op_d       = cmd_op_e'(cmd.CMD_OP);
                    tos_val_d  = cmd.CMD_TOS_DEPTH;
                    err_code_d = ERR_NONE;
                    if (cmd.CMD_OP > OP_LAST_LEGAL) begin
                        err_code_d = ERR_ILLEGAL;
                    end else begin
                        case (cmd_op_e'(cmd.CMD_OP))
                            OP_PUSH_ALU, OP_PUSH_RET, OP_PUSH_ARG, OP_LOAD_MEM:
                                if (full) err_code_d = ERR_OVERFLOW;
                            // DUP both reads and grows the stack, so it can fail either way.
                            OP_DUP:
                                if (full)       err_code_d = ERR_OVERFLOW;
                                else if (empty) err_code_d = ERR_UNDERFLOW;
                            OP_POP, OP_STORE_MEM:
                                if (empty) err_code_d = ERR_UNDERFLOW;
                            OP_SET_TOS:
                                if (cmd.CMD_TOS_DEPTH > MAX_DEPTH) err_code_d = ERR_OVERFLOW;
                            default: ;
                        endcase
                    end
                    if (err_code_d != ERR_NONE) begin
                        state_d = S_ERR;
                    end else begin
                        case (cmd_op_e'(cmd.CMD_OP))
                            OP_PUSH_ALU:  begin state_d = S_PUSH_LATCH; src_d = SRC_ALU; end
                            OP_PUSH_RET:  begin state_d = S_PUSH_LATCH; src_d = SRC_RET; end
                            OP_PUSH_ARG:  begin state_d = S_PUSH_LATCH; src_d = SRC_ARG; end
                            OP_DUP:       begin state_d = S_RD_STK;     src_d = SRC_STK; end
                            OP_LOAD_MEM:  begin state_d = S_RD_MEM;     src_d = SRC_MEM; end
                            OP_POP:       state_d = S_POP;
                            OP_STORE_MEM: state_d = S_RD_STK;
                            OP_SET_TOS:   state_d = S_SET_TOS;
                            default:      nop_done = 1'b1;  // NOP: stays in IDLE
                        endcase
                    end
                end
            end
            // RD_STK is shared by DUP and STORE_MEM; the latched opcode picks the branch.
            S_RD_STK:     state_d = (op_q == OP_DUP) ? S_PUSH_LATCH : S_WM_LATCH;
            S_RD_MEM:     state_d = S_PUSH_LATCH;
            S_PUSH_LATCH: state_d = S_PUSH_WR;
            S_WM_LATCH:   state_d = S_WM_WR;
            default:      state_d = S_IDLE;
        endcase

        // Outputs are registered: load them with the decode of the state being entered.
        strb_d = decode_state(state_d, src_d);
        if (nop_done)
            strb_d.cmd_done = 1'b1;
        // A NOP's done cycle still counts as busy so READY rises the cycle after DONE.
        ready_d = (state_d == S_IDLE) && !nop_done;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            src_q      <= SRC_ALU;
            err_code_q <= ERR_NONE;
            tos_val_q  <= '0;
            ready_q    <= 1'b1;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            err_code_q <= err_code_d;
            tos_val_q  <= tos_val_d;
            ready_q    <= ready_d;
            strb_q     <= strb_d;
        end
    end

    // Depth moves on the same edge the TOS register captures, so it is driven
    // directly from the TOS strobes currently on the outputs.
    stack_depth_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_depth (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (strb_q.ctrl_reg_tos && !strb_q.sel_mux_tos &&  strb_q.sel_tos_updater),
        .dec_i      (strb_q.ctrl_reg_tos && !strb_q.sel_mux_tos && !strb_q.sel_tos_updater),
        .load_i     (strb_q.ctrl_reg_tos &&  strb_q.sel_mux_tos),
        .load_val_i (tos_val_q),
        .depth_o    (STACK_DEPTH),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign cmd.CMD_READY        = ready_q;
    assign cmd.CMD_DONE         = strb_q.cmd_done;
    assign cmd.CMD_ERR          = strb_q.cmd_err;
    assign cmd.ERR_CODE         = err_code_q;
    assign SEL_MUX_STACK        = strb_q.sel_mux_stack;
    assign CTRL_REG_READ_STACK  = strb_q.reg_read_stack;
    assign CTRL_REG_WRITE_STACK = strb_q.reg_write_stack;
    assign CTRL_REG_READ_MEM    = strb_q.reg_read_mem;
    assign CTRL_REG_WRITE_MEM   = strb_q.reg_write_mem;
    assign SEL_MUX_TOS          = strb_q.sel_mux_tos;
    assign CTRL_REG_TOS         = strb_q.ctrl_reg_tos;
    assign SEL_TOS_UPDATER      = strb_q.sel_tos_updater;
    assign CTRL_STACK           = strb_q.ctrl_stack;
    assign CTRL_MEM_EXT         = strb_q.ctrl_mem_ext;
endmodule

// File: tb/tb_stack_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl_sequencer
// Directed, table-driven bench for stack_ctrl_sequencer with ADDR_WIDTH=3
// (MAX_DEPTH=8). Each record gives a command plus the expected strobe word
// for the three cycles after accept, the latency, final ERR_CODE and depth.
// Strobe word bits: [13:11] SEL_MUX_STACK, [10] REG_READ_STACK,
// [9] REG_WRITE_STACK, [8] REG_READ_MEM, [7] REG_WRITE_MEM, [6] SEL_MUX_TOS,
// [5] CTRL_REG_TOS, [4] SEL_TOS_UPDATER, [3] CTRL_STACK, [2] CTRL_MEM_EXT,
// [1] CMD_DONE, [0] CMD_ERR.
// ---------------------------------------------------------------------------
module tb_stack_ctrl_sequencer;
    localparam int AW = 3;

    typedef logic [13:0] obs_t;

    localparam obs_t W_IDLE  = 14'b000_0000_000_0000;
    localparam obs_t W_RDSTK = 14'b000_1000_000_0000;
    localparam obs_t W_RDMEM = 14'b000_0010_000_0000;
    localparam obs_t W_PW    = 14'b000_0000_000_1010;
    localparam obs_t W_POP   = 14'b000_0000_010_0010;
    localparam obs_t W_WML   = 14'b000_0001_000_0000;
    localparam obs_t W_WMW   = 14'b000_0000_010_0110;
    localparam obs_t W_SET   = 14'b000_0000_110_0010;
    localparam obs_t W_ERR   = 14'b000_0000_000_0001;
    localparam obs_t W_NOP   = 14'b000_0000_000_0010;

    function automatic obs_t w_pl(input logic [2:0] src);
        return {src, 11'b0100_011_0000};
    endfunction

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] tos;
        obs_t       e1, e2, e3;
        int         lat;
        logic [1:0] ecode;
        logic [3:0] depth;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic [3:0] tos,
                                input obs_t e1, input obs_t e2, input obs_t e3,
                                input int lat, input logic [1:0] ec, input logic [3:0] d);
        vec_t v;
        v.name = n; v.op = op; v.tos = tos; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.lat = lat; v.ecode = ec; v.depth = d;
        return v;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic [AW:0] STACK_DEPTH;
    logic [2:0]  SEL_MUX_STACK;
    logic        CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM;
    logic        SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT;

    stack_ctrl_sequencer_if #(.ADDR_WIDTH(AW)) cmd_if ();

    stack_ctrl_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd                  (cmd_if),
        .STACK_DEPTH          (STACK_DEPTH),
        .SEL_MUX_STACK        (SEL_MUX_STACK),
        .CTRL_REG_READ_STACK  (CTRL_REG_READ_STACK),
        .CTRL_REG_WRITE_STACK (CTRL_REG_WRITE_STACK),
        .CTRL_REG_READ_MEM    (CTRL_REG_READ_MEM),
        .CTRL_REG_WRITE_MEM   (CTRL_REG_WRITE_MEM),
        .SEL_MUX_TOS          (SEL_MUX_TOS),
        .CTRL_REG_TOS         (CTRL_REG_TOS),
        .SEL_TOS_UPDATER      (SEL_TOS_UPDATER),
        .CTRL_STACK           (CTRL_STACK),
        .CTRL_MEM_EXT         (CTRL_MEM_EXT)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic obs_t observe();
        return {SEL_MUX_STACK, CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM,
                CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK,
                CTRL_MEM_EXT, cmd_if.CMD_DONE, cmd_if.CMD_ERR};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int guard = 0;
        while (cmd_if.CMD_READY !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_if.CMD_READY !== 1'b1)
            chk({nm, "_ready_timeout"}, 32'(cmd_if.CMD_READY), 32'd1);
    endtask

    // Apply one vector: accept at edge T, then check cycles T+1..T+4.
    task automatic run_vec(input vec_t v);
        obs_t exp_w[3];
        exp_w[0] = v.e1; exp_w[1] = v.e2; exp_w[2] = v.e3;
        wait_ready(v.name);
        cmd_if.CMD_OP        = v.op;
        cmd_if.CMD_TOS_DEPTH = {1'b0, v.tos};
        cmd_if.CMD_VALID     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_if.CMD_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("%s_strobe_c%0d", v.name, i + 1), 32'(observe()), 32'(exp_w[i]));
            chk($sformatf("%s_ready_c%0d", v.name, i + 1), 32'(cmd_if.CMD_READY),
                32'((i + 1) > v.lat));
        end
        @(negedge clk);
        chk({v.name, "_ready_end"}, 32'(cmd_if.CMD_READY), 32'd1);
        chk({v.name, "_err_code"}, 32'(cmd_if.ERR_CODE), 32'(v.ecode));
        chk({v.name, "_depth"}, 32'(STACK_DEPTH), 32'(v.depth));
        $display("cmd %-12s op=%0d depth=%0d err_code=%0d", v.name, v.op, STACK_DEPTH, cmd_if.ERR_CODE);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk("push_arg",   4'd3,  4'd0, w_pl(3'b011), W_PW, W_IDLE, 2, 2'b00, 4'd1));
        vecs.push_back(mk("pop",        4'd5,  4'd0, W_POP, W_IDLE, W_IDLE,       1, 2'b00, 4'd0));
        vecs.push_back(mk("pop_empty",  4'd5,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b10, 4'd0));
        vecs.push_back(mk("nop",        4'd0,  4'd0, W_NOP, W_IDLE, W_IDLE,       1, 2'b00, 4'd0));
        vecs.push_back(mk("push_alu",   4'd1,  4'd0, w_pl(3'b000), W_PW, W_IDLE, 2, 2'b00, 4'd1));
        vecs.push_back(mk("push_ret",   4'd2,  4'd0, w_pl(3'b010), W_PW, W_IDLE, 2, 2'b00, 4'd2));
        vecs.push_back(mk("store_mem",  4'd7,  4'd0, W_RDSTK, W_WML, W_WMW,       3, 2'b00, 4'd1));
        vecs.push_back(mk("dup",        4'd4,  4'd0, W_RDSTK, w_pl(3'b100), W_PW, 3, 2'b00, 4'd2));
        vecs.push_back(mk("load_mem",   4'd6,  4'd0, W_RDMEM, w_pl(3'b001), W_PW, 3, 2'b00, 4'd3));
        vecs.push_back(mk("illegal12",  4'd12, 4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b11, 4'd3));
        vecs.push_back(mk("set_tos9",   4'd8,  4'd9, W_ERR, W_IDLE, W_IDLE,       1, 2'b01, 4'd3));
        vecs.push_back(mk("set_tos0",   4'd8,  4'd0, W_SET, W_IDLE, W_IDLE,       1, 2'b00, 4'd0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("fill%0d", i + 1), 4'd1, 4'd0, w_pl(3'b000), W_PW, W_IDLE,
                              2, 2'b00, 4'(i + 1)));
        vecs.push_back(mk("push_full",  4'd1,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b01, 4'd8));
        vecs.push_back(mk("dup_full",   4'd4,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b01, 4'd8));
        vecs.push_back(mk("load_full",  4'd6,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b01, 4'd8));
        vecs.push_back(mk("pop_full",   4'd5,  4'd0, W_POP, W_IDLE, W_IDLE,       1, 2'b00, 4'd7));
        vecs.push_back(mk("set_tos8",   4'd8,  4'd8, W_SET, W_IDLE, W_IDLE,       1, 2'b00, 4'd8));
        vecs.push_back(mk("set_tos0b",  4'd8,  4'd0, W_SET, W_IDLE, W_IDLE,       1, 2'b00, 4'd0));
        vecs.push_back(mk("store_empty",4'd7,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b10, 4'd0));
        vecs.push_back(mk("dup_empty",  4'd4,  4'd0, W_ERR, W_IDLE, W_IDLE,       1, 2'b10, 4'd0));
        vecs.push_back(mk("set_tos5",   4'd8,  4'd5, W_SET, W_IDLE, W_IDLE,       1, 2'b00, 4'd5));

        // Reset: two cycles low, then release.
        reset = 1'b0;
        cmd_if.CMD_OP = 4'd0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_TOS_DEPTH = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_if.CMD_READY), 32'd1);
        chk("reset_depth", 32'(STACK_DEPTH), 32'd0);
        chk("reset_strobes", 32'(observe()), 32'(W_IDLE));
        chk("reset_err_code", 32'(cmd_if.ERR_CODE), 32'd0);
        $display("reset released: ready=%0d depth=%0d", cmd_if.CMD_READY, STACK_DEPTH);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Opcode changes while busy must be ignored (valid held high throughout).
        wait_ready("busy_ignore");
        cmd_if.CMD_OP = 4'd3;
        cmd_if.CMD_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_if.CMD_OP = 4'd5;
        chk("busy_ignore_c1", 32'(observe()), 32'(w_pl(3'b011)));
        @(negedge clk);
        chk("busy_ignore_c2", 32'(observe()), 32'(W_PW));
        cmd_if.CMD_VALID = 1'b0;
        @(negedge clk);
        chk("busy_ignore_depth", 32'(STACK_DEPTH), 32'd6);
        $display("cmd busy_ignore  depth=%0d", STACK_DEPTH);

        // Reset asserted during the RD_MEM cycle of LOAD_MEM abandons the command.
        wait_ready("rst_mid");
        cmd_if.CMD_OP = 4'd6;
        cmd_if.CMD_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_if.CMD_VALID = 1'b0;
        chk("rst_mid_rdmem", 32'(observe()), 32'(W_RDMEM));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_strobes_in_reset", 32'(observe()), 32'(W_IDLE));
        chk("rst_mid_depth", 32'(STACK_DEPTH), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_after_c%0d", i + 1), 32'(observe()), 32'(W_IDLE));
            chk($sformatf("rst_mid_ready_c%0d", i + 1), 32'(cmd_if.CMD_READY), 32'd1);
        end
        chk("rst_mid_depth_end", 32'(STACK_DEPTH), 32'd0);
        $display("cmd rst_mid      depth=%0d", STACK_DEPTH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_ctrl_sequencer.md
# stack_ctrl_sequencer

Command-level sequencer sitting directly upstream of the stack/TOS datapath block. Accepts one stack command at a time from the main control unit over a valid/ready handshake and expands it into the multi-cycle control-strobe sequence (mux selects, register enables, memory writes, TOS update) that block consumes. Tracks stack depth and rejects overflowing/underflowing commands before any strobe is issued.

## Interface
- ADDR_WIDTH, 12, width of TOS/stack address; maximum depth MAX_DEPTH = 2**ADDR_WIDTH.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a rising edge clears all state.
- CMD_OP  in  4  command opcode (see Operation).
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept; high only in IDLE.
- CMD_TOS_DEPTH  in  ADDR_WIDTH+1  depth value loaded by SET_TOS.
- CMD_DONE  out  1  one-cycle pulse on final cycle of a successful command.
- CMD_ERR  out  1  one-cycle pulse on rejected command.
- ERR_CODE  out  2  00 none, 01 overflow, 10 underflow, 11 illegal opcode; held until next accept.
- STACK_DEPTH  out  ADDR_WIDTH+1  current number of stacked entries.
- SEL_MUX_STACK  out  3  000 ALU, 001 mem-read reg, 010 return reg, 011 arg reg, 100 stack-read reg.
- CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM  out  1 each  datapath register enables.
- SEL_MUX_TOS  out  1  0 TOS updater, 1 restore input.
- CTRL_REG_TOS  out  1  TOS register enable.
- SEL_TOS_UPDATER  out  1  1 = TOS+1 (push), 0 = TOS−1 (pop).
- CTRL_STACK, CTRL_MEM_EXT  out  1 each  stack / external memory write enables.

## Operation
- Opcodes: 0 NOP, 1 PUSH_ALU, 2 PUSH_RET, 3 PUSH_ARG, 4 DUP, 5 POP, 6 LOAD_MEM, 7 STORE_MEM, 8 SET_TOS, 9–15 illegal.
- States: IDLE, RD_STK, RD_MEM, PUSH_LATCH, PUSH_WR, POP, WM_LATCH, WM_WR, SET_TOS, ERR.
- All strobes are Moore decodes of the state register; every strobe not listed is 0; SEL_MUX_STACK defaults 000.
- PUSH_ALU/RET/ARG: IDLE → PUSH_LATCH (CTRL_REG_WRITE_STACK=1, SEL_MUX_STACK=src, CTRL_REG_TOS=1, SEL_TOS_UPDATER=1, depth+1) → PUSH_WR (CTRL_STACK=1, CMD_DONE) → IDLE.
- DUP: IDLE → RD_STK (CTRL_REG_READ_STACK=1) → PUSH_LATCH with src 100 → PUSH_WR → IDLE.
- LOAD_MEM: IDLE → RD_MEM (CTRL_REG_READ_MEM=1) → PUSH_LATCH src 001 → PUSH_WR → IDLE.
- POP: IDLE → POP (CTRL_REG_TOS=1, SEL_TOS_UPDATER=0, depth−1, CMD_DONE) → IDLE.
- STORE_MEM: IDLE → RD_STK → WM_LATCH (CTRL_REG_WRITE_MEM=1) → WM_WR (CTRL_MEM_EXT=1, CTRL_REG_TOS=1, SEL_TOS_UPDATER=0, depth−1, CMD_DONE) → IDLE.
- SET_TOS: IDLE → SET_TOS (SEL_MUX_TOS=1, CTRL_REG_TOS=1, depth←CMD_TOS_DEPTH, CMD_DONE) → IDLE.
- NOP: accepted, CMD_DONE pulses next cycle in IDLE-return, no strobes.
- Checks at accept: PUSH_*, DUP, LOAD_MEM with depth==MAX_DEPTH → overflow; POP, DUP, STORE_MEM with depth==0 → underflow; opcode ≥9 → illegal. Rejected command → ERR (CMD_ERR=1, no strobes) → IDLE; depth unchanged.
- SET_TOS with CMD_TOS_DEPTH > MAX_DEPTH → overflow, rejected.

## Timing
- Accept cycle T: CMD_VALID && CMD_READY. First strobe state at T+1.
- Latencies (accept → CMD_DONE cycle): NOP/POP/SET_TOS/ERR 1, PUSH_ALU/RET/ARG 2, DUP/LOAD_MEM/STORE_MEM 3. CMD_READY high again the cycle after CMD_DONE/CMD_ERR.
- STACK_OUT is valid combinationally from REG_TOS_OUT; external memory read data valid in RD_MEM cycle.
- Depth counter updates on the same edge as the TOS register; never wraps (guarded by checks).
- CMD_OP and CMD_TOS_DEPTH sampled only at accept; changes during busy ignored.
- Reset: state IDLE, depth 0, ERR_CODE 00, all strobes 0, CMD_READY=1 from first cycle after reset release. Reset mid-command abandons it; no further strobes.

## Structure
- Package stack_seq_pkg: opcode enum, state enum, SEL_MUX_STACK source constants, ERR_CODE constants.
- One sub-module natural: stack_depth_counter (inc/dec/load, full/empty flags).

## Test plan
- reset=0 two cycles, release → CMD_READY=1, STACK_DEPTH=0, all strobes 0.
- PUSH_ARG at T → T+1 SEL_MUX_STACK=011, CTRL_REG_WRITE_STACK=CTRL_REG_TOS=SEL_TOS_UPDATER=1; T+2 CTRL_STACK=1, CMD_DONE; depth=1.
- ADDR_WIDTH=3: eight PUSH_ALU then ninth → CMD_ERR, ERR_CODE=01, depth stays 8, no strobes.
- POP at depth 0 → ERR_CODE=10; STORE_MEM at depth 2 → RD_STK, WM_LATCH, WM_WR with CTRL_MEM_EXT=1, depth=1.
- DUP at depth 1 → strobes RD_STK, PUSH_LATCH src 100, PUSH_WR; depth=2; opcode 12 → ERR_CODE=11.
- SET_TOS depth 5 then reset asserted during LOAD_MEM RD_MEM cycle → no PUSH strobes, depth=0 after reset.
